// File: rtl/udp_tx_framer.sv
// Ethernet II / IPv4 / UDP transmit framer: wraps a payload byte stream in
// preamble, headers, padding and CRC-32 FCS, emitting one byte per clock.
module udp_tx_framer #(
    parameter logic [47:0] SRC_MAC    = 48'h02_00_00_00_00_01,
    parameter logic [47:0] DEST_MAC   = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [31:0] SRC_IP     = 32'hC0A8_0164,
    parameter logic [31:0] DEST_IP    = 32'hC0A8_010A,
    parameter logic [15:0] SRC_PORT   = 16'd5000,
    parameter logic [15:0] DEST_PORT  = 16'd5001,
    parameter logic [7:0]  TTL        = 8'd64,
    parameter int          IFG_CYCLES = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] payload_len,
    output logic        busy,
    input  logic [7:0]  payload_data,
    input  logic        payload_valid,
    output logic        payload_ready,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    output logic        frame_done,
    output logic        underrun,
    output logic        len_err
);

    typedef enum logic [3:0] {
        S_IDLE, S_PREAMBLE, S_ETH, S_IP, S_UDP, S_PAYLOAD, S_PAD, S_FCS, S_IFG
    } state_t;

    localparam logic [10:0] IFG_LAST = 11'(IFG_CYCLES - 1);

    state_t      state, state_n;
    logic [10:0] cnt, cnt_n, len_q;
    logic [15:0] ident, ip_csum, total_len, udp_len, csum_calc;
    logic [31:0] crc, fcs_word, ip_sum, fold1, fold2;
    logic        bad, accept, reject, tx_en_n, crc_en;
    logic [7:0]  byte_n;
    logic [111:0] eth_vec, eth_sh;
    logic [159:0] ip_vec, ip_sh;
    logic [63:0]  udp_vec, udp_sh;
    logic [31:0]  fcs_sh;

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'd0, d};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    // Header checksum from the latched length and current identification
    always_comb begin
        total_len = {5'd0, len_q} + 16'd28;
        udp_len   = {5'd0, len_q} + 16'd8;
        ip_sum = 32'h4500 + 32'h4000 + {16'd0, total_len} + {16'd0, ident}
               + {16'd0, TTL, 8'h11}
               + {16'd0, SRC_IP[31:16]}  + {16'd0, SRC_IP[15:0]}
               + {16'd0, DEST_IP[31:16]} + {16'd0, DEST_IP[15:0]};
        fold1 = {16'd0, ip_sum[31:16]} + {16'd0, ip_sum[15:0]};
        fold2 = {16'd0, fold1[31:16]} + {16'd0, fold1[15:0]};
        csum_calc = ~fold2[15:0];
    end

    // State/cnt describe the byte currently on tx_data
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 11'd1;
        accept  = 1'b0;
        reject  = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (start) begin
                    if (payload_len <= 16'd1472) begin
                        accept  = 1'b1;
                        state_n = S_PREAMBLE;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            S_PREAMBLE: if (cnt == 11'd7)  begin state_n = S_ETH; cnt_n = '0; end
            S_ETH:      if (cnt == 11'd13) begin state_n = S_IP;  cnt_n = '0; end
            S_IP:       if (cnt == 11'd19) begin state_n = S_UDP; cnt_n = '0; end
            S_UDP: if (cnt == 11'd7) begin
                state_n = (len_q == 11'd0) ? S_PAD : S_PAYLOAD;
                cnt_n   = '0;
            end
            S_PAYLOAD: if (cnt == len_q - 11'd1) begin
                state_n = (len_q < 11'd18) ? S_PAD : S_FCS;
                cnt_n   = '0;
            end
            S_PAD:  if (cnt == 11'd17 - len_q) begin state_n = S_FCS; cnt_n = '0; end
            S_FCS:  if (cnt == 11'd3)          begin state_n = S_IFG; cnt_n = '0; end
            S_IFG:  if (cnt == IFG_LAST)       begin state_n = S_IDLE; cnt_n = '0; end
            default: begin state_n = S_IDLE; cnt_n = '0; end
        endcase
    end

    assign payload_ready = (state_n == S_PAYLOAD);
    assign underrun      = payload_ready & ~payload_valid;

    // Byte to be registered onto tx_data for the upcoming cycle
    always_comb begin
        eth_vec  = {DEST_MAC, SRC_MAC, 16'h0800};
        ip_vec   = {8'h45, 8'h00, total_len, ident, 16'h4000, TTL, 8'h11,
                    ip_csum, SRC_IP, DEST_IP};
        udp_vec  = {SRC_PORT, DEST_PORT, udp_len, 16'h0000};
        fcs_word = ~crc ^ {32{bad}};
        eth_sh   = eth_vec >> {4'd13 - cnt_n[3:0], 3'b000};
        ip_sh    = ip_vec  >> {5'd19 - cnt_n[4:0], 3'b000};
        udp_sh   = udp_vec >> {3'd7 - cnt_n[2:0], 3'b000};
        fcs_sh   = fcs_word >> {cnt_n[1:0], 3'b000};
        byte_n   = 8'h00;
        case (state_n)
            S_PREAMBLE: byte_n = (cnt_n == 11'd7) ? 8'hD5 : 8'h55;
            S_ETH:      byte_n = eth_sh[7:0];
            S_IP:       byte_n = ip_sh[7:0];
            S_UDP:      byte_n = udp_sh[7:0];
            S_PAYLOAD:  byte_n = payload_valid ? payload_data : 8'h00;
            S_FCS:      byte_n = fcs_sh[7:0];
            default:    byte_n = 8'h00;
        endcase
        tx_en_n = (state_n != S_IDLE) && (state_n != S_IFG);
        crc_en  = (state_n == S_ETH) || (state_n == S_IP) || (state_n == S_UDP) ||
                  (state_n == S_PAYLOAD) || (state_n == S_PAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            len_q      <= '0;
            ident      <= '0;
            ip_csum    <= '0;
            crc        <= '1;
            bad        <= 1'b0;
            tx_data    <= '0;
            tx_en      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            tx_data    <= byte_n;
            tx_en      <= tx_en_n;
            busy       <= (state_n != S_IDLE);
            frame_done <= (state_n == S_FCS) && (cnt_n == 11'd3);
            len_err    <= reject;
            if (accept) begin
                len_q <= payload_len[10:0];
                crc   <= '1;
                bad   <= 1'b0;
            end
            if (state == S_PREAMBLE)
                ip_csum <= csum_calc;
            if (crc_en)
                crc <= crc_byte(crc, byte_n);
            // A starved payload slot poisons the FCS so the receiver drops the frame
            if (underrun)
                bad <= 1'b1;
            if (state == S_FCS && cnt == 11'd3)
                ident <= ident + 16'd1;
        end
    end

endmodule

// File: tb/tb_udp_tx_framer.sv
// Randomized self-checking bench for udp_tx_framer; expected frames are built
// byte by byte from the frame layout rules and compared with the tx stream.
module tb_udp_tx_framer;

    localparam logic [47:0] SMAC  = 48'h02_00_00_00_00_01;
    localparam logic [47:0] DMAC  = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [31:0] SIP   = 32'hC0A8_0164;
    localparam logic [31:0] DIP   = 32'hC0A8_010A;
    localparam logic [15:0] SPORT = 16'd5000;
    localparam logic [15:0] DPORT = 16'd5001;
    localparam logic [7:0]  TTLV  = 8'd64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] payload_len = '0;
    logic [7:0]  payload_data = '0;
    logic        payload_valid = 1'b0;
    logic        busy, payload_ready, tx_en, frame_done, underrun, len_err;
    logic [7:0]  tx_data;

    int n_total = 0;
    int n_bad = 0;
    logic [7:0] cap_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] pay_mem[1472];
    int skip_idx = -1;
    int pidx = 0;
    int fd_cnt, ur_cnt, le_cnt, rdy_cnt, ifg_cnt, busy_cnt;
    time start_time, first_tx_time, last_fd_time, prev_fd;
    int exp_ident = 0;
    logic [15:0] exp_csum;
    logic [31:0] exp_fcs;

    udp_tx_framer #(
        .SRC_MAC(SMAC), .DEST_MAC(DMAC), .SRC_IP(SIP), .DEST_IP(DIP),
        .SRC_PORT(SPORT), .DEST_PORT(DPORT), .TTL(TTLV), .IFG_CYCLES(12)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .payload_len(payload_len),
        .busy(busy), .payload_data(payload_data), .payload_valid(payload_valid),
        .payload_ready(payload_ready), .tx_data(tx_data), .tx_en(tx_en),
        .frame_done(frame_done), .underrun(underrun), .len_err(len_err)
    );

    always #5 clk = ~clk;

    // Monitor plus payload source; junk valid/data is offered whenever ready is low
    initial forever begin
        @(negedge clk);
        if (tx_en) begin
            if (cap_q.size() == 0) first_tx_time = $time;
            cap_q.push_back(tx_data);
        end
        if (frame_done) begin fd_cnt++; last_fd_time = $time; end
        if (len_err) le_cnt++;
        if (busy) busy_cnt++;
        if (busy && !tx_en) ifg_cnt++;
        if (payload_ready) begin
            rdy_cnt++;
            payload_data  = pay_mem[pidx];
            payload_valid = (pidx != skip_idx);
            if (pidx < 1471) pidx++;
        end else begin
            payload_data  = 8'($urandom);
            payload_valid = 1'($urandom);
        end
        #1;
        if (underrun) ur_cnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic buildExpected(input int len, input int skip, input int ident);
        logic [15:0] hw[$];
        logic [7:0]  body[$];
        int          sum;
        logic [31:0] c;
        sum = 'h4500 + (len + 28) + ident + 'h4000 + {TTLV, 8'h11}
            + SIP[31:16] + SIP[15:0] + DIP[31:16] + DIP[15:0];
        while (sum > 'hFFFF) sum = (sum & 'hFFFF) + (sum >> 16);
        exp_csum = ~(16'(sum));
        hw = '{DMAC[47:32], DMAC[31:16], DMAC[15:0], SMAC[47:32], SMAC[31:16], SMAC[15:0],
               16'h0800, 16'h4500, 16'(len + 28), 16'(ident), 16'h4000, {TTLV, 8'h11},
               exp_csum, SIP[31:16], SIP[15:0], DIP[31:16], DIP[15:0],
               SPORT, DPORT, 16'(len + 8), 16'h0000};
        foreach (hw[i]) begin
            body.push_back(hw[i][15:8]);
            body.push_back(hw[i][7:0]);
        end
        for (int i = 0; i < len; i++) body.push_back((i == skip) ? 8'h00 : pay_mem[i]);
        while (body.size() < 60) body.push_back(8'h00);
        c = 32'hFFFF_FFFF;
        foreach (body[i]) begin
            c = c ^ {24'd0, body[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        exp_fcs = ~c;
        if (skip >= 0) exp_fcs = ~exp_fcs;
        exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        foreach (body[i]) exp_q.push_back(body[i]);
        for (int k = 0; k < 4; k++) exp_q.push_back(exp_fcs[8*k +: 8]);
    endtask

    // Called on a falling edge; start is held for exactly one cycle
    task automatic applyStimulus(input int len, input int skip, input bit seq);
        for (int i = 0; i < len; i++) pay_mem[i] = seq ? 8'(i) : 8'($urandom);
        skip_idx = skip;
        pidx = 0;
        cap_q.delete();
        fd_cnt = 0; ur_cnt = 0; le_cnt = 0; rdy_cnt = 0; ifg_cnt = 0; busy_cnt = 0;
        buildExpected(len, skip, exp_ident);
        payload_len = 16'(len);
        start = 1'b1;
        start_time = $time;
        @(negedge clk);
        start = 1'b0;
        payload_len = 16'($urandom);
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy && n < 4000) begin @(negedge clk); n++; end
        if (n >= 4000) checkOutput("busy_timeout", 32'd1, 32'd0);
    endtask

    task automatic checkFrame(input int len, input int skip);
        int n_exp, mism, n;
        n_exp = 8 + 42 + ((len < 18) ? 18 : len) + 4;
        n = cap_q.size();
        checkOutput("txen_cycles", 32'(n), 32'(n_exp));
        mism = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= n || cap_q[i] !== exp_q[i]) mism++;
        checkOutput("frame_bytes", 32'(mism), 32'd0);
        if (n >= 54) begin
            checkOutput("total_len", 32'({cap_q[24], cap_q[25]}), 32'(len + 28));
            checkOutput("ip_id", 32'({cap_q[26], cap_q[27]}), 32'(exp_ident));
            checkOutput("ip_csum", 32'({cap_q[32], cap_q[33]}), 32'(exp_csum));
            checkOutput("udp_len", 32'({cap_q[46], cap_q[47]}), 32'(len + 8));
        end
        if (n >= 4)
            checkOutput("fcs", {cap_q[n-1], cap_q[n-2], cap_q[n-3], cap_q[n-4]}, exp_fcs);
        checkOutput("frame_done", 32'(fd_cnt), 32'd1);
        checkOutput("ready_cycles", 32'(rdy_cnt), 32'(len));
        checkOutput("underrun", 32'(ur_cnt), (skip >= 0) ? 32'd1 : 32'd0);
        checkOutput("ifg_cycles", 32'(ifg_cnt), 32'd12);
        checkOutput("start_latency", 32'((first_tx_time - start_time) / 10), 32'd1);
    endtask

    initial begin
        int len_a, len_b, len_r, skip_r, nz, n;
        repeat (3) @(negedge clk);
        checkOutput("rst_outputs",
                    32'({tx_data, tx_en, busy, payload_ready, frame_done, underrun, len_err}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Sequential 18-byte payload: fixed header values are known in advance
        applyStimulus(18, -1, 1'b1);
        waitIdle();
        checkFrame(18, -1);
        if (cap_q.size() >= 54) begin
            checkOutput("t1_total_len", 32'({cap_q[24], cap_q[25]}), 32'h002E);
            checkOutput("t1_udp_len", 32'({cap_q[46], cap_q[47]}), 32'h001A);
            checkOutput("t1_csum", 32'({cap_q[32], cap_q[33]}), 32'hB700);
            checkOutput("t1_ident", 32'({cap_q[26], cap_q[27]}), 32'h0000);
        end
        exp_ident = (exp_ident + 1) & 'hFFFF;

        applyStimulus(4, -1, 1'b0);
        waitIdle();
        checkFrame(4, -1);
        nz = 0;
        for (int i = 54; i < 68 && i < cap_q.size(); i++) if (cap_q[i] != 8'h00) nz++;
        checkOutput("pad_zero", 32'(nz), 32'd0);
        exp_ident = (exp_ident + 1) & 'hFFFF;

        // Back-to-back frames with a stray start during the first one
        len_a = $urandom_range(20, 40);
        applyStimulus(len_a, -1, 1'b0);
        repeat (20) @(negedge clk);
        start = 1'b1; payload_len = 16'd1500;
        @(negedge clk);
        start = 1'b0;
        waitIdle();
        checkFrame(len_a, -1);
        checkOutput("midstart_len_err", 32'(le_cnt), 32'd0);
        prev_fd = last_fd_time;
        exp_ident = (exp_ident + 1) & 'hFFFF;
        len_b = $urandom_range(0, 30);
        applyStimulus(len_b, -1, 1'b0);
        waitIdle();
        checkFrame(len_b, -1);
        checkOutput("b2b_gap", 32'((first_tx_time - prev_fd) / 10), 32'd14);
        exp_ident = (exp_ident + 1) & 'hFFFF;

        applyStimulus(20, 5, 1'b0);
        waitIdle();
        checkFrame(20, 5);
        exp_ident = (exp_ident + 1) & 'hFFFF;

        // Oversize request is rejected outright
        cap_q.delete(); le_cnt = 0; busy_cnt = 0;
        payload_len = 16'd1473; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("len_err_pulse", 32'(le_cnt), 32'd1);
        checkOutput("len_err_busy", 32'(busy_cnt), 32'd0);
        checkOutput("len_err_txen", 32'(cap_q.size()), 32'd0);

        applyStimulus(1472, -1, 1'b0);
        waitIdle();
        checkFrame(1472, -1);
        exp_ident = (exp_ident + 1) & 'hFFFF;

        for (int r = 0; r < 3; r++) begin
            len_r  = $urandom_range(0, 100);
            skip_r = (len_r > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(0, len_r - 1) : -1;
            applyStimulus(len_r, skip_r, 1'b0);
            waitIdle();
            checkFrame(len_r, skip_r);
            exp_ident = (exp_ident + 1) & 'hFFFF;
        end

        // Reset in the middle of the IP header aborts the frame immediately
        applyStimulus(30, -1, 1'b0);
        n = 0;
        while (cap_q.size() < 25 && n < 200) begin @(negedge clk); n++; end
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_tx_en", 32'(tx_en), 32'd0);
        checkOutput("rst_mid_busy", 32'(busy), 32'd0);
        checkOutput("rst_mid_tx_data", 32'(tx_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_ident = 0;
        applyStimulus(25, -1, 1'b0);
        waitIdle();
        checkFrame(25, -1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
